// File: rtl/adc_ctrl.sv
// rtl/adc_ctrl.sv - ADC sweep sequencer producing signed differential bitline results
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   start        single-cycle sweep request (ignored while busy)
//   busy         high from accepted start until the output handshake completes
//   done         single-cycle pulse on the output handshake
//   adc_start    single-cycle conversion request to the macro
//   adc_done     single-cycle conversion-complete pulse from the macro
//   bl_sel       channel select to the macro
//   bl_data      ADC code of the selected channel
//   diff_data    packed signed differences, entry i at [i*(P_ADC_BITS+1) +: P_ADC_BITS+1]
//   diff_valid   diff_data valid, held until diff_ready
//   diff_ready   consumer accepts diff_data
//   timeout_err  sticky: a channel timed out during the current sweep

module adc_ctrl #(
    parameter int P_ADC_CHANNELS   = 20,
    parameter int P_NUM_OUTPUTS    = 10,
    parameter int P_ADC_BITS       = 8,
    parameter int P_TIMEOUT_CYCLES = 255
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     start,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     adc_start,
    input  logic                                     adc_done,
    output logic [$clog2(P_ADC_CHANNELS)-1:0]        bl_sel,
    input  logic [P_ADC_BITS-1:0]                    bl_data,
    output logic [P_NUM_OUTPUTS*(P_ADC_BITS+1)-1:0]  diff_data,
    output logic                                     diff_valid,
    input  logic                                     diff_ready,
    output logic                                     timeout_err
);

    localparam int SEL_W = $clog2(P_ADC_CHANNELS);
    localparam int TMO_W = $clog2(P_TIMEOUT_CYCLES);
    localparam int DW    = P_ADC_BITS + 1;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(P_ADC_CHANNELS - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(P_TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DIFF   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;

    logic [2:0]                        state_q, state_d;
    logic [SEL_W-1:0]                  idx_q, idx_d;
    logic [TMO_W-1:0]                  tmo_q, tmo_d;
    logic                              terr_q, terr_d;
    logic [P_NUM_OUTPUTS*DW-1:0]       diff_q, diff_d;
    logic [P_ADC_BITS-1:0]             raw_q [P_ADC_CHANNELS];

    logic                              raw_we;
    logic [P_ADC_BITS-1:0]             raw_wdata;
    logic                              chan_end;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        terr_d    = terr_q;
        diff_d    = diff_q;
        raw_we    = 1'b0;
        raw_wdata = '0;
        chan_end  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    terr_d  = 1'b0;
                    idx_d   = '0;
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A conversion that lands on the last timeout cycle still wins.
                if (adc_done) begin
                    raw_we    = 1'b1;
                    raw_wdata = bl_data;
                    chan_end  = 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    raw_we    = 1'b1;
                    raw_wdata = '0;
                    terr_d    = 1'b1;
                    chan_end  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end

                if (chan_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DIFF;
                    end else begin
                        idx_d   = idx_q + SEL_W'(1);
                        state_d = S_SAMPLE;
                    end
                end
            end

            S_DIFF: begin
                // Zero-extend both codes so the 9-bit difference covers -255..+255.
                for (int i = 0; i < P_NUM_OUTPUTS; i++) begin
                    diff_d[i*DW +: DW] = $signed({1'b0, raw_q[i]})
                                       - $signed({1'b0, raw_q[i+P_NUM_OUTPUTS]});
                end
                state_d = S_OUT;
            end

            S_OUT: begin
                if (diff_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            tmo_q   <= '0;
            terr_q  <= 1'b0;
            diff_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            terr_q  <= terr_d;
            diff_q  <= diff_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_ADC_CHANNELS; i++) begin
                raw_q[i] <= '0;
            end
        end else if (raw_we) begin
            raw_q[idx_q] <= raw_wdata;
        end
    end

    // Outputs decode straight from state so reset clears them immediately.
    assign busy        = (state_q != S_IDLE);
    assign adc_start   = (state_q == S_SAMPLE);
    assign bl_sel      = ((state_q == S_SAMPLE) || (state_q == S_WAIT)) ? idx_q : '0;
    assign diff_valid  = (state_q == S_OUT);
    assign done        = (state_q == S_OUT) && diff_ready;
    assign diff_data   = diff_q;
    assign timeout_err = terr_q;

`ifndef SYNTHESIS
    a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
        adc_start |=> !adc_start);
    a_sel_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(bl_sel) < P_ADC_CHANNELS);
    a_diff_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (diff_valid && !diff_ready) |=> $stable(diff_data));
`endif

endmodule

// File: tb/tb_adc_ctrl.sv
// tb/tb_adc_ctrl.sv - directed self-checking bench for adc_ctrl

module tb_adc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        adc_start;
    logic        adc_done;
    logic [4:0]  bl_sel;
    logic [7:0]  bl_data = 8'd0;
    logic [89:0] diff_data;
    logic        diff_valid;
    logic        diff_ready = 1'b0;
    logic        timeout_err;

    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    int          mode = 0;
    int          start_cnt = 0;
    logic [4:0]  sel_log [512];
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [4:0]  sel = 5'd0;

    int total = 0;
    int bad = 0;

    assign adc_done = model_done | spur_done;

    always #5 clk = ~clk;

    adc_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .bl_sel      (bl_sel),
        .bl_data     (bl_data),
        .diff_data   (diff_data),
        .diff_valid  (diff_valid),
        .diff_ready  (diff_ready),
        .timeout_err (timeout_err)
    );

    // Macro response code for channel j under the current mode.
    function automatic logic [7:0] code(int m, logic [4:0] j);
        int jj;
        jj = int'(j);
        case (m)
            1: return (jj < 10) ? 8'd0 : 8'd255;
            2: return (jj < 10) ? 8'd255 : 8'd0;
            default: return (jj < 10) ? 8'(20 + jj) : 8'(5 + (jj - 10));
        endcase
    endfunction

    // Macro model: answers 3 cycles after adc_start; mode 3 never answers channel 7.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            cnt = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    model_done = 1'b1;
                    bl_data = code(mode, sel);
                    pend = 1'b0;
                end
            end
            if (adc_start) begin
                if (start_cnt < 512) sel_log[start_cnt] = bl_sel;
                start_cnt = start_cnt + 1;
                if (!(mode == 3 && bl_sel == 5'd7)) begin
                    pend = 1'b1;
                    cnt = 3;
                    sel = bl_sel;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [89:0] obs, input logic [89:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [89:0] pack_all(input logic [8:0] v);
        logic [89:0] r;
        for (int i = 0; i < 10; i++) r[i*9 +: 9] = v;
        return r;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = 0;
        while (!diff_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        chk("valid_reached", {89'd0, diff_valid}, 90'd1);
    endtask

    task automatic check_seq(input string tag, input int base);
        int errs;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (sel_log[base + i] !== 5'(i)) errs++;
        end
        chk({tag, "_pulses"}, 90'(start_cnt - base), 90'd20);
        chk({tag, "_order"}, 90'(errs), 90'd0);
    endtask

    task automatic handshake(input string tag, input logic [89:0] exp);
        diff_ready = 1'b1;
        #1;
        chk({tag, "_done_pulse"}, {89'd0, done}, 90'd1);
        @(negedge clk);
        diff_ready = 1'b0;
        chk({tag, "_done_low"}, {89'd0, done}, 90'd0);
        chk({tag, "_busy_low"}, {89'd0, busy}, 90'd0);
        chk({tag, "_valid_low"}, {89'd0, diff_valid}, 90'd0);
        chk({tag, "_data_kept"}, diff_data, exp);
    endtask

    initial begin
        int base;
        int lat;
        int badcyc;
        logic [89:0] exp_to;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", {89'd0, busy}, 90'd0);
        chk("rst_adc_start", {89'd0, adc_start}, 90'd0);
        chk("rst_bl_sel", {85'd0, bl_sel}, 90'd0);
        chk("rst_valid", {89'd0, diff_valid}, 90'd0);
        chk("rst_data", diff_data, 90'd0);
        chk("rst_terr", {89'd0, timeout_err}, 90'd0);
        rst_n = 1'b1;

        // Nominal sweep: every difference is 15
        mode = 0;
        base = start_cnt;
        pulse_start();
        chk("nom_busy", {89'd0, busy}, 90'd1);
        wait_valid(500, lat);
        chk("nom_latency", 90'(lat), 90'd81);
        check_seq("nom", base);
        chk("nom_data", diff_data, pack_all(9'd15));
        chk("nom_terr", {89'd0, timeout_err}, 90'd0);
        handshake("nom", pack_all(9'd15));

        // Extremes
        mode = 1;
        pulse_start();
        wait_valid(500, lat);
        chk("neg_ext_data", diff_data, pack_all(9'h101));
        handshake("neg_ext", pack_all(9'h101));
        mode = 2;
        pulse_start();
        wait_valid(500, lat);
        chk("pos_ext_data", diff_data, pack_all(9'h0FF));
        handshake("pos_ext", pack_all(9'h0FF));

        // Backpressure for 50 cycles
        mode = 0;
        pulse_start();
        wait_valid(500, lat);
        badcyc = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (diff_valid !== 1'b1 || diff_data !== pack_all(9'd15) || done !== 1'b0 || busy !== 1'b1)
                badcyc++;
        end
        chk("bp_hold_cycles_bad", 90'(badcyc), 90'd0);
        handshake("bp", pack_all(9'd15));

        // Timeout on channel 7: diff[7] = 0 - 12
        mode = 3;
        pulse_start();
        wait_valid(2000, lat);
        exp_to = pack_all(9'd15);
        exp_to[63 +: 9] = 9'h1F4;
        chk("to_data", diff_data, exp_to);
        chk("to_terr", {89'd0, timeout_err}, 90'd1);
        handshake("to", exp_to);
        chk("to_terr_sticky", {89'd0, timeout_err}, 90'd1);

        // Next start clears timeout_err; start re-pulsed mid-sweep is ignored
        mode = 0;
        base = start_cnt;
        pulse_start();
        chk("to_terr_cleared", {89'd0, timeout_err}, 90'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid(500, lat);
        check_seq("restart", base);
        chk("restart_data", diff_data, pack_all(9'd15));
        handshake("restart", pack_all(9'd15));

        // Spurious adc_done in IDLE
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_busy", {89'd0, busy}, 90'd0);
        chk("spur_adc_start", {89'd0, adc_start}, 90'd0);
        chk("spur_data", diff_data, pack_all(9'd15));

        // Reset mid-sweep at channel 12
        mode = 0;
        pulse_start();
        lat = 0;
        while (!(adc_start && bl_sel == 5'd12) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("mid_reached_ch12", {85'd0, bl_sel}, 90'd12);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {89'd0, busy}, 90'd0);
        chk("mid_rst_adc_start", {89'd0, adc_start}, 90'd0);
        chk("mid_rst_bl_sel", {85'd0, bl_sel}, 90'd0);
        chk("mid_rst_data", diff_data, 90'd0);
        chk("mid_rst_valid", {89'd0, diff_valid}, 90'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = start_cnt;
        pulse_start();
        wait_valid(500, lat);
        chk("post_rst_latency", 90'(lat), 90'd81);
        check_seq("post_rst", base);
        chk("post_rst_data", diff_data, pack_all(9'd15));
        handshake("post_rst", pack_all(9'd15));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_ctrl.md
Name: adc_ctrl

Overview:
Sequencer directly downstream of the CIM macro's ADC interface. Once a CIM compute finishes, it steps bl_sel across all 20 bitline channels. For each channel it pulses adc_start, waits for adc_done and captures bl_data. After the sweep it forms 10 signed differential results (positive column i minus negative column i+10) and presents them on a valid/ready output to the neuron/membrane update stage.

Parameters:
P_ADC_CHANNELS, 20, number of BL channels (first half positive columns, second half negative columns).
P_NUM_OUTPUTS, 10, number of differential outputs; must equal P_ADC_CHANNELS/2.
P_ADC_BITS, 8, unsigned ADC code width.
P_TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT per channel before the channel is abandoned.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle sweep request, issued after cim_done
busy  output  1  high from the accepted start until the output handshake completes
done  output  1  single-cycle pulse when the output handshake completes
adc_start  output  1  single-cycle conversion request to the macro
adc_done  input  1  single-cycle conversion-complete pulse from the macro
bl_sel  output  $clog2(P_ADC_CHANNELS)  channel select to the macro
bl_data  input  P_ADC_BITS  ADC code for the currently selected channel
diff_data  output  P_NUM_OUTPUTS*(P_ADC_BITS+1)  packed signed differences, entry i at bits [i*(P_ADC_BITS+1) +: P_ADC_BITS+1]
diff_valid  output  1  diff_data is valid; held until diff_ready
diff_ready  input  1  consumer accepts diff_data
timeout_err  output  1  sticky flag: at least one channel timed out in the current sweep

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE; busy, done, adc_start, diff_valid and timeout_err are 0; bl_sel is 0; diff_data is 0; raw buffer is 0; channel index is 0; timeout counter is 0.
- States: IDLE, SAMPLE, WAIT, DIFF, OUT.
- IDLE:
  - bl_sel = 0.
  - On start: clear timeout_err, set index to 0, go to SAMPLE.
- SAMPLE: adc_start = 1 for exactly this one cycle; bl_sel = index; clear the timeout counter; go to WAIT.
- WAIT:
  - bl_sel stays equal to index.
  - adc_done = 1: capture bl_data into raw[index] in that same cycle.
  - Timeout counter reaches P_TIMEOUT_CYCLES-1 with no adc_done: write 0 to raw[index] and set timeout_err.
  - Either event, with index == P_ADC_CHANNELS-1: go to DIFF.
  - Either event, otherwise: increment index and go to SAMPLE.
- DIFF: in one cycle, register diff[i] = signed({1'b0,raw[i]}) - signed({1'b0,raw[i+P_NUM_OUTPUTS]}), i = 0..P_NUM_OUTPUTS-1. Result range is -255..+255 in 9 bits, with no saturation. Go to OUT.
- OUT:
  - diff_valid = 1 and diff_data stays stable until diff_ready is sampled high.
  - On that cycle: done pulses, diff_valid drops on the next edge, go to IDLE.
  - diff_data keeps its last value after the handshake.
- busy = (state != IDLE).
- start while busy is ignored, and the sweep is not restarted.
- adc_done outside WAIT is ignored, and the raw buffer is not written.
- bl_sel never exceeds P_ADC_CHANNELS-1.
- Per-channel cost: 1 SAMPLE cycle plus the WAIT cycles up to and including adc_done. Total latency from start to diff_valid = 1 + Σ(per-channel) + 1 (DIFF) cycles, plus the IDLE→SAMPLE edge.
- Reset mid-sweep: immediately returns to reset values. No adc_start is issued after rst_n asserts. A stale adc_done after reset release is ignored, per the rule above.
- Assertions (sim only):
  - adc_start is never high on two consecutive cycles.
  - bl_sel < P_ADC_CHANNELS.
  - diff_data is stable while diff_valid && !diff_ready.

Test Plan:
- Bench macro model with 3-cycle latency, popcount p=10, returning bl_data = 2p+j for j<10 and p/2+(j-10) for j≥10; start pulse → 20 adc_start pulses with bl_sel 0..19 in order, then diff_valid with every diff[i] = 15 and timeout_err = 0; diff_ready held high → done pulses once and busy falls.
- Extremes: positive channels return 0 and negative channels return 255 → every diff[i] = -255 (9'h101); swap the values → every diff[i] = +255.
- Backpressure: hold diff_ready low for 50 cycles → diff_valid and diff_data stay constant and done stays 0; raise diff_ready → handshake completes, done pulses, state returns to IDLE.
- Timeout: the responder never answers channel 7 → after P_TIMEOUT_CYCLES the sweep proceeds with raw[7] = 0 and diff[7] = -raw[17]; timeout_err = 1 at diff_valid; the next start clears timeout_err.
- Protocol robustness: start re-pulsed during WAIT → no restart and still exactly 20 adc_start pulses; a spurious adc_done in IDLE → no state change.
- Reset mid-sweep at channel 12 → all outputs return to reset values asynchronously; a fresh start then completes a full 0..19 sweep with correct diffs.
